id_scan_ctrl: RTL and testbench



---
 rtl/id_scan_pkg.sv | 17 +
 rtl/id_char_class.sv | 19 +
 rtl/id_scan_ctrl.sv | 177 +++++++++++++++++
 tb/tb_id_scan_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_scan_pkg.sv
// Shared encodings for the identifier-recognition path: FSM states and character classes.
// Pure declarations; no logic, no latency.
package id_scan_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ID   = 2'b01,
        S_SKIP = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        CL_DELIM  = 2'b00,
        CL_LETTER = 2'b01,
        CL_DIGIT  = 2'b10
    } cls_e;

endpackage

// File: rtl/id_char_class.sv
// ASCII character classifier: letter, digit or delimiter.
// Purely combinational, zero latency, no flow control.
module id_char_class
    import id_scan_pkg::*;
(
    input  logic [7:0] chr,
    output cls_e       cls
);

    always_comb begin
        cls = CL_DELIM;
        if ((chr >= 8'h41 && chr <= 8'h5A) || (chr >= 8'h61 && chr <= 8'h7A)) begin
            cls = CL_LETTER;
        end else if (chr >= 8'h30 && chr <= 8'h39) begin
            cls = CL_DIGIT;
        end
    end

endmodule

// File: rtl/id_scan_ctrl.sv
// Identifier boundary tracker: emits one token record per letter-led alnum run, 1 cycle after the terminating char.
// Input stalls (in_ready=0) only while a record is held and the consumer is not taking it.
module id_scan_ctrl
    import id_scan_pkg::*;
#(
    parameter int IDX_W = 8,
    parameter int LEN_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       char,
    input  logic             in_valid,
    input  logic             in_eos,
    output logic             in_ready,
    output logic             tok_valid,
    input  logic             tok_ready,
    output logic [IDX_W-1:0] tok_start,
    output logic [LEN_W-1:0] tok_len,
    output logic             tok_digit_end,
    output logic             tok_ovf,
    output logic [CNT_W-1:0] tok_count,
    output logic             busy
);

    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   pos_q, pos_d;
    logic [IDX_W-1:0]   cur_start_q, cur_start_d;
    logic [LEN_W-1:0]   cur_len_q, cur_len_d;
    logic               cur_dig_q, cur_dig_d;
    logic               cur_ovf_q, cur_ovf_d;
    logic               tok_valid_q, tok_valid_d;
    logic [IDX_W-1:0]   tok_start_q, tok_start_d;
    logic [LEN_W-1:0]   tok_len_q, tok_len_d;
    logic               tok_dig_q, tok_dig_d;
    logic               tok_ovf_q, tok_ovf_d;
    logic [CNT_W-1:0]   tok_count_q, tok_count_d;

    cls_e               cls;
    logic               accept;
    logic               emit_cur, emit_run;
    logic [IDX_W-1:0]   run_start;
    logic [LEN_W-1:0]   run_len;
    logic               run_dig, run_ovf;

    id_char_class u_class (
        .chr (char),
        .cls (cls)
    );

    assign in_ready = !tok_valid_q || tok_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        // Run record as it would look with the current char included.
        run_dig = (cls == CL_DIGIT);
        if (state_q == S_ID) begin
            run_start = cur_start_q;
            run_ovf   = cur_ovf_q || (cur_len_q == LEN_MAX);
            run_len   = (cur_len_q == LEN_MAX) ? cur_len_q : cur_len_q + 1'b1;
        end else begin
            run_start = pos_q;
            run_ovf   = 1'b0;
            run_len   = LEN_W'(1);
        end

        state_d     = state_q;
        pos_d       = pos_q;
        cur_start_d = cur_start_q;
        cur_len_d   = cur_len_q;
        cur_dig_d   = cur_dig_q;
        cur_ovf_d   = cur_ovf_q;
        emit_cur    = 1'b0;
        emit_run    = 1'b0;

        if (accept) begin
            pos_d = in_eos ? '0 : pos_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (accept && cls == CL_LETTER) begin
                    if (in_eos) begin
                        emit_run = 1'b1;
                    end else begin
                        state_d = S_ID;
                    end
                end else if (accept && cls == CL_DIGIT && !in_eos) begin
                    state_d = S_SKIP;
                end
            end
            S_ID: begin
                if (accept) begin
                    if (cls == CL_DELIM) begin
                        emit_cur = 1'b1;
                        state_d  = S_IDLE;
                    end else if (in_eos) begin
                        emit_run = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
            end
            S_SKIP: begin
                if (accept && (cls == CL_DELIM || in_eos)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept && cls != CL_DELIM && state_d == S_ID) begin
            cur_start_d = run_start;
            cur_len_d   = run_len;
            cur_dig_d   = run_dig;
            cur_ovf_d   = run_ovf;
        end

        tok_valid_d = tok_valid_q;
        tok_start_d = tok_start_q;
        tok_len_d   = tok_len_q;
        tok_dig_d   = tok_dig_q;
        tok_ovf_d   = tok_ovf_q;
        tok_count_d = tok_count_q;
        // A new emit wins over the consumer draining the held record.
        if (emit_cur || emit_run) begin
            tok_valid_d = 1'b1;
            tok_start_d = emit_run ? run_start : cur_start_q;
            tok_len_d   = emit_run ? run_len   : cur_len_q;
            tok_dig_d   = emit_run ? run_dig   : cur_dig_q;
            tok_ovf_d   = emit_run ? run_ovf   : cur_ovf_q;
            tok_count_d = tok_count_q + 1'b1;
        end else if (tok_valid_q && tok_ready) begin
            tok_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pos_q       <= '0;
            cur_start_q <= '0;
            cur_len_q   <= '0;
            cur_dig_q   <= 1'b0;
            cur_ovf_q   <= 1'b0;
            tok_valid_q <= 1'b0;
            tok_start_q <= '0;
            tok_len_q   <= '0;
            tok_dig_q   <= 1'b0;
            tok_ovf_q   <= 1'b0;
            tok_count_q <= '0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            cur_start_q <= cur_start_d;
            cur_len_q   <= cur_len_d;
            cur_dig_q   <= cur_dig_d;
            cur_ovf_q   <= cur_ovf_d;
            tok_valid_q <= tok_valid_d;
            tok_start_q <= tok_start_d;
            tok_len_q   <= tok_len_d;
            tok_dig_q   <= tok_dig_d;
            tok_ovf_q   <= tok_ovf_d;
            tok_count_q <= tok_count_d;
        end
    end

    assign tok_valid     = tok_valid_q;
    assign tok_start     = tok_start_q;
    assign tok_len       = tok_len_q;
    assign tok_digit_end = tok_dig_q;
    assign tok_ovf       = tok_ovf_q;
    assign tok_count     = tok_count_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_id_scan_ctrl.sv
// Scoreboard bench for id_scan_ctrl: expected token records are queued as characters are driven
// and matched against records captured at each tok_valid && tok_ready handshake.
module tb_id_scan_ctrl;

    localparam int IDX_W = 8;
    localparam int LEN_W = 5;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic [IDX_W-1:0] start;
        logic [LEN_W-1:0] len;
        logic             dig;
        logic             ovf;
    } tok_t;

    logic             clk;
    logic             reset;
    logic [7:0]       chr;
    logic             in_valid;
    logic             in_eos;
    logic             in_ready;
    logic             tok_valid;
    logic             tok_ready;
    logic [IDX_W-1:0] tok_start;
    logic [LEN_W-1:0] tok_len;
    logic             tok_digit_end;
    logic             tok_ovf;
    logic [CNT_W-1:0] tok_count;
    logic             busy;

    tok_t exp_q[$];
    tok_t got_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    logic acc;

    id_scan_ctrl #(.IDX_W(IDX_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .char          (chr),
        .in_valid      (in_valid),
        .in_eos        (in_eos),
        .in_ready      (in_ready),
        .tok_valid     (tok_valid),
        .tok_ready     (tok_ready),
        .tok_start     (tok_start),
        .tok_len       (tok_len),
        .tok_digit_end (tok_digit_end),
        .tok_ovf       (tok_ovf),
        .tok_count     (tok_count),
        .busy          (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock: sample handshakes at the falling edge, then let the rising edge act.
    task automatic tick();
        @(negedge clk);
        if (!reset && tok_valid === 1'b1 && tok_ready === 1'b1)
            got_q.push_back(tok_t'{tok_start, tok_len, tok_digit_end, tok_ovf});
        acc = !reset && in_valid && (in_ready === 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_eos   = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_char(input logic [7:0] c, input logic eos);
        int n;
        n        = 0;
        chr      = c;
        in_valid = 1'b1;
        in_eos   = eos;
        do begin
            tick();
            n++;
        end while (!acc && n < 300);
        in_valid = 1'b0;
        in_eos   = 1'b0;
        if (!acc) begin
            n_total++;
            $display("FAIL accept_timeout: char %h not accepted, in_ready=%b required 1", c, in_ready);
        end
    endtask

    task automatic send_str(input string s, input logic eos_last);
        for (int i = 0; i < s.len(); i++)
            send_char(s[i], eos_last && (i == s.len() - 1));
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_eos    = 1'b0;
        tok_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if ({tok_valid, busy, tok_digit_end, tok_ovf} !== 4'b0000)
            $display("FAIL reset_flags: tok_valid/busy/dig/ovf=%b required 0000", {tok_valid, busy, tok_digit_end, tok_ovf});
        else n_pass++;
        n_total++;
        if (tok_start !== '0 || tok_len !== '0 || tok_count !== '0)
            $display("FAIL reset_regs: start=%0d len=%0d count=%0d required 0 0 0", tok_start, tok_len, tok_count);
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_basic();
        tok_t g, e;
        do_reset();
        exp_q.push_back(tok_t'{8'd0, 5'd3, 1'b1, 1'b0});
        send_str("ab1", 1'b0);
        n_total++;
        if (tok_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL basic_pre: tok_valid=%b busy=%b required 0 1", tok_valid, busy);
        else n_pass++;
        send_char(" ", 1'b0);
        n_total++;
        if (tok_valid !== 1'b1 || tok_start !== 8'd0 || tok_len !== 5'd3 || tok_digit_end !== 1'b1)
            $display("FAIL basic_latency: valid=%b start=%0d len=%0d dig=%b required 1 0 3 1", tok_valid, tok_start, tok_len, tok_digit_end);
        else n_pass++;
        send_str("9z,", 1'b0);
        idle(4);
        n_total++;
        if (got_q.size() !== exp_q.size()) $display("FAIL basic_ntok: got %0d tokens required %0d", got_q.size(), exp_q.size());
        else n_pass++;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); n_total++;
            if (g !== e) $display("FAIL basic_tok: got %0d/%0d/%b/%b required %0d/%0d/%b/%b", g.start, g.len, g.dig, g.ovf, e.start, e.len, e.dig, e.ovf);
            else n_pass++;
        end
        n_total++;
        if (tok_count !== 16'd1) $display("FAIL basic_count: got %0d required 1", tok_count);
        else n_pass++;
    endtask

    task automatic test_eos();
        tok_t g, e;
        do_reset();
        exp_q.push_back(tok_t'{8'd0, 5'd1, 1'b0, 1'b0});
        send_char("x", 1'b1);
        exp_q.push_back(tok_t'{8'd0, 5'd1, 1'b0, 1'b0});
        send_char("y", 1'b1);
        exp_q.push_back(tok_t'{8'd0, 5'd1, 1'b0, 1'b0});
        send_str("q;", 1'b0);
        send_char("9", 1'b1);
        exp_q.push_back(tok_t'{8'd0, 5'd3, 1'b1, 1'b0});
        send_str("ab7", 1'b1);
        n_total++;
        if (busy !== 1'b0) $display("FAIL eos_busy: got %b required 0", busy);
        else n_pass++;
        idle(4);
        n_total++;
        if (got_q.size() !== exp_q.size()) $display("FAIL eos_ntok: got %0d tokens required %0d", got_q.size(), exp_q.size());
        else n_pass++;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); n_total++;
            if (g !== e) $display("FAIL eos_tok: got %0d/%0d/%b/%b required %0d/%0d/%b/%b", g.start, g.len, g.dig, g.ovf, e.start, e.len, e.dig, e.ovf);
            else n_pass++;
        end
        n_total++;
        if (tok_count !== 16'd4) $display("FAIL eos_count: got %0d required 4", tok_count);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        tok_t g, e;
        do_reset();
        tok_ready = 1'b0;
        exp_q.push_back(tok_t'{8'd0, 5'd1, 1'b0, 1'b0});
        send_str("a,", 1'b0);
        chr      = "b";
        in_valid = 1'b1;
        repeat (3) tick();
        n_total++;
        if (in_ready !== 1'b0 || acc !== 1'b0) $display("FAIL b2b_stall: in_ready=%b accepted=%b required 0 0", in_ready, acc);
        else n_pass++;
        n_total++;
        if (tok_valid !== 1'b1 || tok_start !== 8'd0) $display("FAIL b2b_hold: valid=%b start=%0d required 1 0", tok_valid, tok_start);
        else n_pass++;
        tok_ready = 1'b1;
        exp_q.push_back(tok_t'{8'd2, 5'd1, 1'b0, 1'b0});
        send_str("b,", 1'b0);
        idle(4);
        n_total++;
        if (got_q.size() !== exp_q.size()) $display("FAIL b2b_ntok: got %0d tokens required %0d", got_q.size(), exp_q.size());
        else n_pass++;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); n_total++;
            if (g !== e) $display("FAIL b2b_tok: got %0d/%0d/%b/%b required %0d/%0d/%b/%b", g.start, g.len, g.dig, g.ovf, e.start, e.len, e.dig, e.ovf);
            else n_pass++;
        end
        n_total++;
        if (tok_count !== 16'd2) $display("FAIL b2b_count: got %0d required 2", tok_count);
        else n_pass++;
    endtask

    task automatic test_saturate_and_wrap();
        tok_t g, e;
        do_reset();
        exp_q.push_back(tok_t'{8'd0, 5'd31, 1'b0, 1'b1});
        for (int i = 0; i < 40; i++) send_char("m", 1'b0);
        send_char(";", 1'b0);
        idle(3);
        do_reset();
        exp_q.push_back(tok_t'{8'd254, 5'd2, 1'b0, 1'b0});
        for (int i = 0; i < 254; i++) send_char(" ", 1'b0);
        send_str("ab;", 1'b0);
        exp_q.push_back(tok_t'{8'd1, 5'd1, 1'b0, 1'b0});
        send_str("c;", 1'b0);
        idle(4);
        n_total++;
        if (got_q.size() !== exp_q.size()) $display("FAIL wrap_ntok: got %0d tokens required %0d", got_q.size(), exp_q.size());
        else n_pass++;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); n_total++;
            if (g !== e) $display("FAIL wrap_tok: got %0d/%0d/%b/%b required %0d/%0d/%b/%b", g.start, g.len, g.dig, g.ovf, e.start, e.len, e.dig, e.ovf);
            else n_pass++;
        end
    endtask

    task automatic test_saturate_only();
        tok_t g, e;
        do_reset();
        exp_q.push_back(tok_t'{8'd0, 5'd31, 1'b0, 1'b1});
        for (int i = 0; i < 40; i++) send_char("m", 1'b0);
        send_char(";", 1'b0);
        idle(4);
        n_total++;
        if (got_q.size() !== exp_q.size()) $display("FAIL sat_ntok: got %0d tokens required %0d", got_q.size(), exp_q.size());
        else n_pass++;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); n_total++;
            if (g !== e) $display("FAIL sat_tok: got %0d/%0d/%b/%b required %0d/%0d/%b/%b", g.start, g.len, g.dig, g.ovf, e.start, e.len, e.dig, e.ovf);
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        tok_t g, e;
        do_reset();
        send_str("abc", 1'b0);
        n_total++;
        if (busy !== 1'b1) $display("FAIL midrst_busy_pre: got %b required 1", busy);
        else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_total++;
        if (busy !== 1'b0 || tok_valid !== 1'b0) $display("FAIL midrst_state: busy=%b valid=%b required 0 0", busy, tok_valid);
        else n_pass++;
        exp_q.push_back(tok_t'{8'd0, 5'd1, 1'b0, 1'b0});
        send_str("d;", 1'b0);
        idle(4);
        n_total++;
        if (got_q.size() !== exp_q.size()) $display("FAIL midrst_ntok: got %0d tokens required %0d", got_q.size(), exp_q.size());
        else n_pass++;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); n_total++;
            if (g !== e) $display("FAIL midrst_tok: got %0d/%0d/%b/%b required %0d/%0d/%b/%b", g.start, g.len, g.dig, g.ovf, e.start, e.len, e.dig, e.ovf);
            else n_pass++;
        end
        n_total++;
        if (tok_count !== 16'd1) $display("FAIL midrst_count: got %0d required 1", tok_count);
        else n_pass++;
    endtask

    initial begin
        reset     = 1'b1;
        chr       = 8'h00;
        in_valid  = 1'b0;
        in_eos    = 1'b0;
        tok_ready = 1'b1;
        acc       = 1'b0;
        test_reset();
        test_basic();
        test_eos();
        test_back_to_back();
        test_saturate_only();
        test_saturate_and_wrap();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
